// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite single-port SRAM slave with configurable wait states and a two-cycle ERROR response.
// Word-addressed storage with little-endian byte/halfword lane writes.
module ahb_lite_sram_slave #(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0      // 0..15
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t           state;
    logic [3:0]       wait_cnt;
    logic             dp_valid;
    logic             dp_write;
    logic [IDX_W-1:0] dp_idx;
    logic [3:0]       dp_lanes;

    logic [31:0]      mem [MEM_DEPTH];

    logic             accept;
    logic             addr_ok;
    logic             align_ok;
    logic             legal;
    logic [3:0]       lanes;
    logic [IDX_W-1:0] idx;
    logic             unused_htrans0;

    assign unused_htrans0 = HTRANS[0];

    // Address-phase decode; only consulted on the edge a transfer is accepted.
    assign accept  = HSEL & HREADY & HTRANS[1];
    assign addr_ok = {2'b00, HADDR[31:2]} < 32'(MEM_DEPTH);
    assign idx     = HADDR[IDX_W+1:2];
    assign legal   = align_ok & addr_ok;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        align_ok = 1'b0;
        lanes    = 4'b0000;
        case (HSIZE)
            3'd0: begin
                align_ok = 1'b1;
                lanes    = 4'b0001 << HADDR[1:0];
            end
            3'd1: begin
                align_ok = ~HADDR[0];
                lanes    = HADDR[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                align_ok = (HADDR[1:0] == 2'b00);
                lanes    = 4'b1111;
            end
            default: ;
        endcase
    end

    // Outputs are decoded from state and the latched data-phase fields only.
    assign HREADYOUT = (state == ST_IDLE) || (state == ST_ERR2);
    assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);
    assign HRDATA    = (dp_valid && !dp_write) ? mem[dp_idx] : 32'h0;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_lanes <= 4'b0000;
        end else begin
            case (state)
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= ST_IDLE;
                    end
                end
                ST_ERR1: begin
                    state <= ST_ERR2;
                end
                default: begin
                    // IDLE or ERR2: any data phase ends here and a new transfer may start.
                    state    <= ST_IDLE;
                    dp_valid <= 1'b0;
                    if (accept) begin
                        if (!legal) begin
                            state <= ST_ERR1;
                        end else begin
                            dp_valid <= 1'b1;
                            dp_write <= HWRITE;
                            dp_idx   <= idx;
                            dp_lanes <= lanes;
                            if (WAIT_STATES != 0) begin
                                state    <= ST_WAIT;
                                wait_cnt <= 4'(WAIT_STATES);
                            end
                        end
                    end
                end
            endcase
        end
    end

    // NOTE: the array has no reset; reset only suppresses a write that would commit on that edge.
    always_ff @(posedge HCLK) begin
        if (HRESETn && HREADYOUT && dp_valid && dp_write) begin
            for (int b = 0; b < 4; b++) begin
                if (dp_lanes[b]) begin
                    mem[dp_idx][8*b +: 8] <= HWDATA[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Randomized self-checking bench: two slaves (0 and 3 wait states) on shared bus wires,
// checked cycle by cycle against a transfer-level reference model.
module tb_ahb_lite_sram_slave;

    localparam int DEPTH = 256;
    localparam int WS0   = 0;
    localparam int WS1   = 3;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk;
    logic        hresetn;
    logic        hsel0, hsel1;
    logic [31:0] haddr, hwdata;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        ro0, rs0, ro1, rs1;
    logic [31:0] rd0, rd1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_rdata;
    logic [31:0] model [2][DEPTH];
    xfer_t       q[$];

    ahb_lite_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(WS0)) u_dut0 (
        .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel0), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HTRANS(htrans), .HWDATA(hwdata), .HREADY(ro0),
        .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0)
    );

    ahb_lite_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_STATES(WS1)) u_dut1 (
        .HCLK(clk), .HRESETn(hresetn), .HSEL(hsel1), .HADDR(haddr), .HWRITE(hwrite),
        .HSIZE(hsize), .HTRANS(htrans), .HWDATA(hwdata), .HREADY(ro1),
        .HRDATA(rd1), .HREADYOUT(ro1), .HRESP(rs1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input xfer_t x);
        if (x.size > 3'd2) return 1'b0;
        if (x.size == 3'd1 && x.addr[0]) return 1'b0;
        if (x.size == 3'd2 && x.addr[1:0] != 2'b00) return 1'b0;
        if ((x.addr >> 2) >= 32'(DEPTH)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_write(input int d, input xfer_t x);
        int idx;
        int lane;
        bit hit;
        idx  = int'(x.addr >> 2);
        lane = int'(x.addr[1:0]);
        for (int b = 0; b < 4; b++) begin
            case (x.size)
                3'd0:    hit = (b == lane);
                3'd1:    hit = ((b / 2) == (lane / 2));
                default: hit = 1'b1;
            endcase
            if (hit) model[d][idx][8*b +: 8] = x.wdata[8*b +: 8];
        end
    endfunction

    task automatic push(input logic sel, input logic [1:0] trans, input logic write,
                        input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.write = write;
        x.size = size; x.addr = addr; x.wdata = wdata;
        q.push_back(x);
    endtask

    task automatic drive_addr(input int d, input bit v, input xfer_t x);
        hsel0 = 1'b0;
        hsel1 = 1'b0;
        if (v) begin
            if (d == 0) hsel0 = x.sel;
            else        hsel1 = x.sel;
            htrans = x.trans; haddr = x.addr; hwrite = x.write; hsize = x.size;
        end else begin
            htrans = 2'd0; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd0;
        end
    endtask

    // Plays the queued transfers on slave d with full address/data pipelining and
    // checks every cycle: legal phases last ws+1 cycles, errors last exactly two.
    task automatic run_seq(input int d);
        xfer_t       ap, dp;
        bit          ap_v = 1'b0;
        bit          dp_v = 1'b0;
        int          k = 0;
        int          ws = (d == 0) ? WS0 : WS1;
        logic        ro, rs;
        logic [31:0] rd;
        ap = '0;
        dp = '0;
        forever begin
            if (!ap_v && q.size() > 0) begin
                ap   = q.pop_front();
                ap_v = 1'b1;
            end
            if (!ap_v && !dp_v) break;
            drive_addr(d, ap_v, ap);
            hwdata = dp_v ? dp.wdata : 32'h0;
            @(negedge clk);
            ro = (d == 0) ? ro0 : ro1;
            rs = (d == 0) ? rs0 : rs1;
            rd = (d == 0) ? rd0 : rd1;
            if (dp_v) begin
                if (is_legal(dp)) begin
                    check("ready", 32'(ro), 32'(k == ws));
                    check("resp", 32'(rs), 32'd0);
                    if (ro) begin
                        if (dp.write) begin
                            check("wr_rdata", rd, 32'h0);
                            model_write(d, dp);
                        end else begin
                            check("rd_data", rd, model[d][int'(dp.addr >> 2)]);
                            last_rdata = rd;
                        end
                    end
                end else begin
                    check("err_ready", 32'(ro), 32'(k == 1));
                    check("err_resp", 32'(rs), 32'd1);
                    if (ro) check("err_rdata", rd, 32'h0);
                end
                if (!ro && k > ws + 2) begin
                    check("dp_timeout", 32'(k), 32'(ws + 1));
                    q.delete();
                    drive_addr(d, 1'b0, ap);
                    @(posedge clk); #1;
                    return;
                end
            end else begin
                check("idle_ready", 32'(ro), 32'd1);
                check("idle_resp", 32'(rs), 32'd0);
            end
            if (ro) begin
                dp_v = 1'b0;
                if (ap_v) begin
                    if (ap.sel && ap.trans[1]) begin
                        dp   = ap;
                        dp_v = 1'b1;
                    end
                    ap_v = 1'b0;
                end
                k = 0;
            end else begin
                k++;
            end
            @(posedge clk); #1;
        end
        drive_addr(d, 1'b0, ap);
    endtask

    task automatic gen_random(input int n);
        int          r, w;
        logic [1:0]  tr;
        logic [2:0]  sz;
        logic [1:0]  off;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            r  = int'($urandom_range(0, 15));
            tr = (r == 0) ? 2'd0 : (r == 1) ? 2'd1 : (r < 8) ? 2'd3 : 2'd2;
            sz = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            w  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 15))
                                              : int'($urandom_range(0, DEPTH + 3));
            case (sz)
                3'd0:    off = 2'($urandom_range(0, 3));
                3'd1:    off = {1'($urandom_range(0, 1)), 1'b0};
                default: off = 2'b00;
            endcase
            if ($urandom_range(0, 7) == 0) off = 2'($urandom_range(0, 3));
            a = 32'(w * 4) + 32'(off);
            if ($urandom_range(0, 31) == 0) a[31] = 1'b1;
            push($urandom_range(0, 15) != 0, tr, 1'($urandom_range(0, 1)), sz, a, $urandom());
        end
    endtask

    initial begin
        xfer_t x;
        x = '0;
        last_rdata = 32'h0;
        hresetn = 1'b0;
        hwdata  = 32'h0;
        drive_addr(0, 1'b0, x);

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        #1 hresetn = 1'b1;
        @(negedge clk);
        check("rst_ready0", 32'(ro0), 32'd1);
        check("rst_resp0", 32'(rs0), 32'd0);
        check("rst_rdata0", rd0, 32'h0);
        check("rst_ready1", 32'(ro1), 32'd1);
        check("rst_resp1", 32'(rs1), 32'd0);
        check("rst_rdata1", rd1, 32'h0);
        @(posedge clk); #1;

        // Known contents everywhere, back-to-back word writes.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) push(1'b1, 2'd2, 1'b1, 3'd2, 32'(i * 4), $urandom());
            run_seq(d);
        end

        // Write then pipelined read of the same word.
        push(1'b1, 2'd2, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        push(1'b1, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0);
        run_seq(0);
        check("t2_rdata", last_rdata, 32'hDEADBEEF);

        push(1'b1, 2'd2, 1'b1, 3'd2, 32'h10, 32'hCAFEF00D);
        push(1'b1, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0);
        run_seq(1);
        check("t4_rdata", last_rdata, 32'hCAFEF00D);

        // Byte and halfword lanes.
        for (int d = 0; d < 2; d++) begin
            push(1'b1, 2'd2, 1'b1, 3'd2, 32'h20, 32'h0);
            push(1'b1, 2'd3, 1'b1, 3'd0, 32'h21, 32'h0000AA00);
            push(1'b1, 2'd3, 1'b1, 3'd1, 32'h22, 32'h12340000);
            push(1'b1, 2'd2, 1'b0, 3'd2, 32'h20, 32'h0);
            run_seq(d);
            check("t3_rdata", last_rdata, 32'h1234AA00);
        end

        // Illegal accesses, then readback of the words they would have hit.
        for (int d = 0; d < 2; d++) begin
            push(1'b1, 2'd2, 1'b1, 3'd2, 32'h02, 32'hFFFFFFFF);
            push(1'b1, 2'd2, 1'b1, 3'd2, 32'(4 * DEPTH), 32'hFFFFFFFF);
            push(1'b1, 2'd2, 1'b1, 3'd1, 32'h05, 32'hFFFFFFFF);
            push(1'b1, 2'd2, 1'b1, 3'd3, 32'h04, 32'hFFFFFFFF);
            push(1'b1, 2'd2, 1'b0, 3'd2, 32'h80000000, 32'h0);
            push(1'b1, 2'd2, 1'b0, 3'd2, 32'h00, 32'h0);
            push(1'b1, 2'd2, 1'b0, 3'd2, 32'h04, 32'h0);
            run_seq(d);
        end

        // BUSY / IDLE / deselected transfers have no effect.
        for (int d = 0; d < 2; d++) begin
            push(1'b1, 2'd1, 1'b1, 3'd2, 32'h30, 32'h11111111);
            push(1'b1, 2'd0, 1'b1, 3'd2, 32'h30, 32'h22222222);
            push(1'b0, 2'd2, 1'b1, 3'd2, 32'h30, 32'h33333333);
            push(1'b1, 2'd2, 1'b0, 3'd2, 32'h30, 32'h0);
            run_seq(d);
        end

        // Reset while the 3-wait-state slave is stalling a write.
        x.sel = 1'b1; x.trans = 2'd2; x.write = 1'b1; x.size = 3'd2; x.addr = 32'h40;
        drive_addr(1, 1'b1, x);
        @(posedge clk); #1;
        drive_addr(1, 1'b0, x);
        hwdata = 32'h5555AAAA;
        @(negedge clk);
        check("r1_wait_ready", 32'(ro1), 32'd0);
        @(posedge clk); #1;
        hresetn = 1'b0;
        @(posedge clk); #1;
        hresetn = 1'b1;
        @(negedge clk);
        check("r1_ready", 32'(ro1), 32'd1);
        check("r1_resp", 32'(rs1), 32'd0);
        check("r1_rdata", rd1, 32'h0);
        @(posedge clk); #1;
        push(1'b1, 2'd2, 1'b0, 3'd2, 32'h40, 32'h0);
        run_seq(1);

        // Reset on the completing edge of a zero-wait write.
        x.addr = 32'h44;
        drive_addr(0, 1'b1, x);
        @(posedge clk); #1;
        drive_addr(0, 1'b0, x);
        hwdata  = 32'h77778888;
        hresetn = 1'b0;
        @(posedge clk); #1;
        hresetn = 1'b1;
        @(negedge clk);
        check("r2_ready", 32'(ro0), 32'd1);
        check("r2_resp", 32'(rs0), 32'd0);
        @(posedge clk); #1;
        push(1'b1, 2'd2, 1'b0, 3'd2, 32'h44, 32'h0);
        run_seq(0);

        // Randomized mix.
        for (int d = 0; d < 2; d++) begin
            gen_random(250);
            run_seq(d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
